// File: rtl/countdown_controller_if.sv
// Keypad-to-controller bundle and controller-to-display/alarm bundle.
// master: keypad adapter side (drives strobes, observes display/alarm).
// slave : countdown_controller side.
//   keydown_start/confirm/clear/num : one-cycle key strobes
//   num                             : digit value, qualified by keydown_num
//   digits                          : BCD {m1,m0,s1,s0}
//   state                           : ENTRY=0 ARMED=1 RUNNING=2 PAUSED=3 DONE=4
//   running / alarm                 : RUNNING / DONE indicators
interface countdown_controller_if;
    logic        keydown_start;
    logic        keydown_confirm;
    logic        keydown_clear;
    logic        keydown_num;
    logic [3:0]  num;
    logic [15:0] digits;
    logic [2:0]  state;
    logic        running;
    logic        alarm;

    modport master (
        output keydown_start, keydown_confirm, keydown_clear, keydown_num, num,
        input  digits, state, running, alarm
    );

    modport slave (
        input  keydown_start, keydown_confirm, keydown_clear, keydown_num, num,
        output digits, state, running, alarm
    );
endinterface

// File: rtl/countdown_controller.sv
// Countdown timer sequencer: collects a BCD MM:SS entry from keypad strobes,
// validates and arms it, counts it down once per TICK_DIV clocks and raises
// the alarm at 00:00.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : countdown_controller_if.slave (key strobes in, display/alarm out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ENTRY   | collecting digits into buf_q; display shows buf_q
// ARMED   | valid time loaded into cnt_q, waiting for start
// RUNNING | prescaler counting, cnt_q decremented once per second
// PAUSED  | prescaler and cnt_q frozen, waiting for start or clear
// DONE    | cnt_q reached 00:00, alarm raised until any key
module countdown_controller #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    countdown_controller_if.slave  bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        ARMED   = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    buf_q, buf_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [PW-1:0]  pre_q, pre_d;

    logic           num_ok;
    logic           any_key;
    logic [15:0]    cnt_dec;

    // One-second BCD decrement of MM:SS; seconds digits wrap 0->59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    assign num_ok  = bus.keydown_num && (bus.num <= 4'd9);
    assign any_key = bus.keydown_start | bus.keydown_confirm |
                     bus.keydown_clear | bus.keydown_num;
    assign cnt_dec = bcd_dec(cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTRY;
            buf_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        case (state_q)
            ENTRY: begin
                if (bus.keydown_clear) begin
                    buf_d = '0;
                end else if (bus.keydown_start) begin
                    // start outranks confirm/num but does nothing here
                    buf_d = buf_q;
                end else if (bus.keydown_confirm) begin
                    buf_d = '0;
                    if ((buf_q[7:4] <= 4'd5) && (buf_q != 16'h0000)) begin
                        cnt_d   = buf_q;
                        state_d = ARMED;
                    end
                end else if (num_ok) begin
                    buf_d = {buf_q[11:0], bus.num};
                end
            end
            ARMED: begin
                if (bus.keydown_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ENTRY;
                end else if (bus.keydown_start) begin
                    pre_d   = '0;
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (bus.keydown_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    pre_d   = '0;
                    state_d = ENTRY;
                end else if (bus.keydown_start) begin
                    state_d = PAUSED;
                end else if (any_key) begin
                    // ignored keys still freeze the prescaler so a tick that
                    // coincides with them is deferred rather than lost
                    pre_d = pre_q;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (cnt_q != 16'h0000) begin
                        cnt_d = cnt_dec;
                    end
                    if ((cnt_q == 16'h0000) || (cnt_dec == 16'h0000)) begin
                        state_d = DONE;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            PAUSED: begin
                if (bus.keydown_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    pre_d   = '0;
                    state_d = ENTRY;
                end else if (bus.keydown_start) begin
                    state_d = RUNNING;
                end
            end
            DONE: begin
                if (any_key) begin
                    buf_d   = '0;
                    state_d = ENTRY;
                end
            end
            default: begin
                buf_d   = '0;
                cnt_d   = '0;
                pre_d   = '0;
                state_d = ENTRY;
            end
        endcase
    end

    assign bus.digits  = (state_q == ENTRY) ? buf_q : cnt_q;
    assign bus.state   = state_q;
    assign bus.running = (state_q == RUNNING);
    assign bus.alarm   = (state_q == DONE);

endmodule

// File: tb/tb_countdown_controller.sv
// Self-checking bench for countdown_controller with TICK_DIV=4.
// Directed scenarios use literal expectations; the randomized scenario is
// checked against a seconds-based reference model of the timer.
module tb_countdown_controller;

    localparam int TD = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    countdown_controller_if bus ();

    countdown_controller #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entry kept as a 4-digit decimal number, time kept as
    // plain seconds.
    int m_state;
    int m_entry;
    int m_secs;
    int m_pre;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_entry = 0; m_secs = 0; m_pre = 0;
        end else begin
            case (m_state)
                0: begin
                    if (bus.keydown_clear) m_entry = 0;
                    else if (bus.keydown_start) m_entry = m_entry;
                    else if (bus.keydown_confirm) begin
                        if (((m_entry / 10) % 10) <= 5 && m_entry != 0) begin
                            m_secs  = (m_entry / 100) * 60 + (m_entry % 100);
                            m_state = 1;
                        end
                        m_entry = 0;
                    end else if (bus.keydown_num && bus.num <= 9)
                        m_entry = (m_entry * 10 + int'(bus.num)) % 10000;
                end
                1: begin
                    if (bus.keydown_clear) begin
                        m_entry = 0; m_secs = 0; m_state = 0;
                    end else if (bus.keydown_start) begin
                        m_pre = 0; m_state = 2;
                    end
                end
                2: begin
                    if (bus.keydown_clear) begin
                        m_entry = 0; m_secs = 0; m_pre = 0; m_state = 0;
                    end else if (bus.keydown_start) m_state = 3;
                    else if (bus.keydown_confirm || bus.keydown_num) m_pre = m_pre;
                    else if (m_pre == TD - 1) begin
                        m_pre  = 0;
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_state = 4;
                    end else m_pre = m_pre + 1;
                end
                3: begin
                    if (bus.keydown_clear) begin
                        m_entry = 0; m_secs = 0; m_pre = 0; m_state = 0;
                    end else if (bus.keydown_start) m_state = 2;
                end
                default: begin
                    if (bus.keydown_start || bus.keydown_confirm ||
                        bus.keydown_clear || bus.keydown_num) begin
                        m_entry = 0; m_state = 0;
                    end
                end
            endcase
        end
    end

    function automatic logic [15:0] dec_to_bcd(input int d);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    task automatic idle_keys();
        bus.keydown_start   = 1'b0;
        bus.keydown_confirm = 1'b0;
        bus.keydown_clear   = 1'b0;
        bus.keydown_num     = 1'b0;
        bus.num             = 4'd0;
    endtask

    // k: 0 start, 1 confirm, 2 clear, 3 num
    task automatic press(input int k, input logic [3:0] v);
        idle_keys();
        case (k)
            0: bus.keydown_start   = 1'b1;
            1: bus.keydown_confirm = 1'b1;
            2: bus.keydown_clear   = 1'b1;
            default: begin bus.keydown_num = 1'b1; bus.num = v; end
        endcase
        @(posedge clk); #1;
        idle_keys();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic enter4(input logic [3:0] a, b, c, d);
        press(3, a); press(3, b); press(3, c); press(3, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_keys();
        cycles(2);
        tests++;
        if (bus.state !== 3'd0 || bus.digits !== 16'h0 || bus.running !== 1'b0 || bus.alarm !== 1'b0) begin
            fails++;
            $display("FAIL reset: state=%0d digits=%h run=%b alarm=%b, required 0 0000 0 0",
                     bus.state, bus.digits, bus.running, bus.alarm);
        end
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_entry_countdown();
        enter4(0, 1, 3, 0);
        press(1, 0);
        tests++;
        if (bus.state !== 3'd1 || bus.digits !== 16'h0130) begin
            fails++;
            $display("FAIL armed: state=%0d digits=%h, required 1 0130", bus.state, bus.digits);
        end
        press(0, 0);
        cycles(3);
        tests++;
        if (bus.digits !== 16'h0130 || bus.running !== 1'b1) begin
            fails++;
            $display("FAIL pre_tick: digits=%h run=%b, required 0130 1", bus.digits, bus.running);
        end
        cycles(1);
        tests++;
        if (bus.digits !== 16'h0129) begin
            fails++;
            $display("FAIL first_tick: digits=%h, required 0129", bus.digits);
        end
        cycles(89 * TD - 1);
        tests++;
        if (bus.digits !== 16'h0001 || bus.state !== 3'd2) begin
            fails++;
            $display("FAIL last_second: digits=%h state=%0d, required 0001 2", bus.digits, bus.state);
        end
        cycles(1);
        tests++;
        if (bus.digits !== 16'h0000 || bus.state !== 3'd4 || bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL done: digits=%h state=%0d alarm=%b run=%b, required 0000 4 1 0",
                     bus.digits, bus.state, bus.alarm, bus.running);
        end
        press(2, 0);
    endtask

    task automatic test_invalid_entry();
        enter4(0, 0, 7, 5);
        press(1, 0);
        tests++;
        if (bus.state !== 3'd0 || bus.digits !== 16'h0000) begin
            fails++;
            $display("FAIL invalid_s1: state=%0d digits=%h, required 0 0000", bus.state, bus.digits);
        end
        press(1, 0);
        tests++;
        if (bus.state !== 3'd0) begin
            fails++;
            $display("FAIL zero_confirm: state=%0d, required 0", bus.state);
        end
        press(3, 4'd10);
        tests++;
        if (bus.digits !== 16'h0000) begin
            fails++;
            $display("FAIL num_gt9: digits=%h, required 0000", bus.digits);
        end
    endtask

    task automatic test_shift_clear();
        press(3, 1); enter4(2, 3, 4, 5);
        tests++;
        if (bus.digits !== 16'h2345) begin
            fails++;
            $display("FAIL shift: digits=%h, required 2345", bus.digits);
        end
        // clear outranks a simultaneous digit
        bus.keydown_clear = 1'b1; bus.keydown_num = 1'b1; bus.num = 4'd6;
        @(posedge clk); #1;
        idle_keys();
        tests++;
        if (bus.digits !== 16'h0000 || bus.state !== 3'd0) begin
            fails++;
            $display("FAIL clear: digits=%h state=%0d, required 0000 0", bus.digits, bus.state);
        end
    endtask

    task automatic test_pause_resume();
        int bad;
        enter4(0, 0, 1, 0);
        press(1, 0);
        press(0, 0);
        cycles(2);
        press(0, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.state !== 3'd3 || bus.digits !== 16'h0010) bad++;
            cycles(1);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL paused_hold: %0d bad cycles, required 0", bad);
        end
        press(0, 0);
        cycles(1);
        tests++;
        if (bus.digits !== 16'h0010) begin
            fails++;
            $display("FAIL resume_early: digits=%h, required 0010", bus.digits);
        end
        cycles(1);
        tests++;
        if (bus.digits !== 16'h0009 || bus.state !== 3'd2) begin
            fails++;
            $display("FAIL resume_tick: digits=%h state=%0d, required 0009 2", bus.digits, bus.state);
        end
        press(2, 0);
    endtask

    task automatic test_borrow();
        enter4(1, 0, 0, 0);
        press(1, 0);
        press(0, 0);
        cycles(TD);
        tests++;
        if (bus.digits !== 16'h0959) begin
            fails++;
            $display("FAIL borrow: digits=%h, required 0959", bus.digits);
        end
        press(2, 0);
    endtask

    task automatic test_done_exit();
        enter4(0, 0, 0, 1);
        press(1, 0);
        press(0, 0);
        cycles(TD);
        tests++;
        if (bus.state !== 3'd4 || bus.alarm !== 1'b1) begin
            fails++;
            $display("FAIL one_second_done: state=%0d alarm=%b, required 4 1", bus.state, bus.alarm);
        end
        press(3, 7);
        tests++;
        if (bus.state !== 3'd0 || bus.digits !== 16'h0000 || bus.alarm !== 1'b0) begin
            fails++;
            $display("FAIL done_exit: state=%0d digits=%h alarm=%b, required 0 0000 0",
                     bus.state, bus.digits, bus.alarm);
        end
    endtask

    task automatic test_reset_midrun();
        enter4(0, 0, 0, 5);
        press(1, 0);
        press(0, 0);
        cycles(TD + 1);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.state !== 3'd0 || bus.digits !== 16'h0 || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: state=%0d digits=%h run=%b, required 0 0000 0",
                     bus.state, bus.digits, bus.running);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        int r;
        logic [15:0] exp_d;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            idle_keys();
            r = $urandom_range(0, 99);
            if (r < 1) bus.keydown_clear = 1'b1;
            else if (r < 5) bus.keydown_start = 1'b1;
            else if (r < 9) bus.keydown_confirm = 1'b1;
            else if (r < 19) begin
                bus.keydown_num = 1'b1;
                bus.num = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 1));
            end else if (r < 21) begin
                bus.keydown_start = 1'($urandom_range(0, 1));
                bus.keydown_confirm = 1'b1;
                bus.keydown_num = 1'b1;
                bus.num = 4'($urandom_range(0, 9));
            end
            @(posedge clk); #1;
            exp_d = (m_state == 0) ? dec_to_bcd(m_entry)
                                   : dec_to_bcd((m_secs / 60) * 100 + (m_secs % 60));
            tests++;
            if (bus.state !== 3'(m_state) || bus.digits !== exp_d ||
                bus.running !== (m_state == 2) || bus.alarm !== (m_state == 4)) begin
                fails++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: state=%0d digits=%h run=%b alarm=%b, required %0d %h %b %b",
                             i, bus.state, bus.digits, bus.running, bus.alarm,
                             m_state, exp_d, m_state == 2, m_state == 4);
            end
        end
        idle_keys();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_entry_countdown();
        test_invalid_entry();
        test_shift_clear();
        test_pause_resume();
        test_borrow();
        test_done_exit();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_controller.md
# countdown_controller

Sequencing controller for the countdown timer. It consumes the decoded keypad strobes (start, confirm, clear, numeric digit), collects a BCD MM:SS time entry, and validates and arms it. It then runs the countdown from an internal one-second prescaler and raises the alarm at zero. It sits between the keypad adapter and the display/alarm drivers and owns the only copy of the timer value.

## Interface
- TICK_DIV, 50_000_000: clock cycles per countdown second; must be ≥ 2.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- keydown_start  in  1  one-cycle strobe, start/pause key.
- keydown_confirm  in  1  one-cycle strobe, confirm key.
- keydown_clear  in  1  one-cycle strobe, clear key.
- keydown_num  in  1  one-cycle strobe, digit key.
- num  in  4  digit value 0-9, qualified by keydown_num.
- digits  out  16  BCD display value {m1,m0,s1,s0}.
- state  out  3  ENTRY=0, ARMED=1, RUNNING=2, PAUSED=3, DONE=4.
- running  out  1  high only in RUNNING.
- alarm  out  1  high only in DONE.

## Operation
- Registers:
  - entry buffer `buf[15:0]`.
  - time counter `cnt[15:0]`.
  - prescaler `pre`, with width `$clog2(TICK_DIV)`.
  - `state`.
- `digits` = `buf` in ENTRY, `cnt` in all other states.
- Key priority if several strobes are high in one cycle: clear > start > confirm > num.
- A keydown_num with num > 9 is ignored.
- ENTRY:
  - num: `buf <= {buf[11:0], num}`; the oldest digit (m1) is dropped.
  - clear: `buf <= 0`.
  - confirm, valid entry: requires s1 ≤ 5 and `buf` ≠ 0. Action: `cnt <= buf`, `buf <= 0`, go to ARMED.
  - confirm, invalid entry: `buf <= 0`, stay in ENTRY.
  - start: ignored.
- ARMED:
  - start: `pre <= 0`, go to RUNNING.
  - clear: `buf <= 0`, `cnt <= 0`, go to ENTRY.
  - num/confirm: ignored.
- RUNNING:
  - Every cycle `pre` increments. When `pre == TICK_DIV-1`, set `pre <= 0` and decrement `cnt` once in BCD.
  - BCD decrement: s0 borrows to s1. s1 wraps 0→5 and borrows to m0. m0 wraps 0→9 and borrows to m1.
  - Maximum value is 99:59. `cnt` never underflows.
  - If the decremented value is 0000: go to DONE on that same edge.
  - start: go to PAUSED; `pre` and `cnt` hold.
  - clear: `buf`, `cnt`, `pre` <= 0; go to ENTRY.
  - A key strobe on a tick edge wins: no decrement that cycle.
- PAUSED:
  - start: go to RUNNING, resuming `pre` from its held value.
  - clear: as in RUNNING.
  - Other keys: ignored.
- DONE:
  - `alarm` = 1; `cnt` = 0.
  - Any strobe (start/confirm/clear/num): `buf <= 0`, go to ENTRY.
  - The strobe that exits DONE is consumed and does not load a digit.
- Reset (async, any state including mid-run):
  - `state` = ENTRY; `buf`, `cnt`, `pre` = 0.
  - Outputs: `digits` = 0, `running` = 0, `alarm` = 0.

## Timing
- Every output comes directly from a register, or is a mux of registers selected by `state`. No input-to-output combinational path.
- Key latency: a strobe sampled at edge k is reflected in `state`/`digits` after edge k.
- Running cadence:
  - The first decrement comes TICK_DIV edges after the edge that accepted start from ARMED.
  - Subsequent decrements follow every TICK_DIV edges.
- Pause/resume: if paused with `pre == p`, the next decrement is TICK_DIV−p edges after the resume edge.
- DONE entry occurs on the same edge as the decrement that reaches 00:00. `alarm` is high from that edge on.

## Test plan
(all with TICK_DIV=4)
- Entry and countdown:
  - Stimulus: digits 0,1,3,0; confirm; start.
  - Response: after confirm, state=1, digits=0x0130. 4 edges after start, digits=0x0129. After 90×4 edges, digits=0x0000, state=4, alarm=1, running=0.
- Invalid entry:
  - Stimulus: digits 0,0,7,5; confirm.
  - Response: state=0, digits=0x0000.
  - Stimulus: confirm with `buf`=0.
  - Response: stays in ENTRY.
- Shift and clear:
  - Stimulus: digits 1,2,3,4,5.
  - Response: digits=0x2345.
  - Stimulus: clear.
  - Response: digits=0x0000, state=0.
- Pause/resume:
  - Stimulus: load 0010 and start. Press start again when `pre`=2.
  - Response: state=3 and digits=0x0010 held for 20 cycles.
  - Stimulus: start.
  - Response: digits=0x0009 exactly 2 edges later.
- Borrow chain:
  - Stimulus: load 1000 and run 1 tick.
  - Response: digits=0x0959.
- DONE exit and reset:
  - Stimulus: in DONE, press num=7.
  - Response: state=0, digits=0x0000, alarm=0.
  - Stimulus: assert rst mid-RUNNING.
  - Response: immediately state=0, digits=0, running=0.
